i2s_rx_deser: RTL and testbench

Serial-to-parallel receive stage of the I2S transceiver, placed directly downstream of the transmit FIFO's serial output (`dout`/`ws`). It runs in the bit-clock domain and frames the incoming serial stream with `ws`. It reconstructs 32-bit left/right samples using the same `standard`, `stereo` and `frame_size` controls as the transmit side. Completed words are handed to the consumer through a 2-entry valid/ready buffer.

---
 rtl/i2s_rx_deser.sv | 210 +++++++++++++++++++++
 tb/tb_i2s_rx_deser.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_rx_deser
//  Purpose  : I2S serial-to-parallel receiver. Frames the bit stream with ws
//             (Philips, left- or right-justified; 16 or 32-bit slots) and
//             hands MSB-aligned 32-bit words to a DEPTH-entry valid/ready
//             buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_deser #(
    parameter int DEPTH = 2
) (
    input  logic        rclk,
    input  logic        rst,
    input  logic        sd,
    input  logic        ws,
    input  logic [1:0]  standard,
    input  logic        stereo,
    input  logic        frame_size,
    output logic [31:0] dout,
    output logic        dout_ch,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        overrun,
    output logic        sync_err
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam int                c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Framer state. Slot controls are latched at slot start so a control
    // change in mid-slot only affects the following slot.
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        ws_q;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic        ch_q, ch_d;
    logic        phil_q, phil_d;
    logic        rj_q, rj_d;
    logic        w32_q, w32_d;
    logic        stereo_q, stereo_d;
    logic        sync_err_q, sync_err_d;

    logic        w_edge;
    logic [31:0] w_shift;
    logic [31:0] w_word;
    logic [5:0]  w_slot_len;
    logic [5:0]  w_cnt_inc;
    logic        w_active;
    logic        w_in_phil;
    logic        w_in_rj;
    logic        w_push;

    assign w_edge     = (ws != ws_q);
    assign w_shift    = {shreg_q[30:0], sd};
    assign w_slot_len = w32_q ? 6'd32 : 6'd16;
    assign w_cnt_inc  = cnt_q + 6'd1;
    assign w_active   = (cnt_q < w_slot_len);
    // Encoding 11 falls back to Philips.
    assign w_in_rj    = (standard == 2'b10);
    assign w_in_phil  = (standard != 2'b01) && (standard != 2'b10);
    // The shift register always holds the most recent bits of the slot, so
    // the low 16 bits are the whole 16-bit slot or the tail of a 32-bit
    // right-justified slot.
    assign w_word     = (w32_q && !rj_q) ? w_shift : {w_shift[15:0], 16'h0000};

    // Next-state logic for the framer, including the push strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        ch_d       = ch_q;
        phil_d     = phil_q;
        rj_d       = rj_q;
        w32_d      = w32_q;
        stereo_d   = stereo_q;
        sync_err_d = 1'b0;
        w_push     = 1'b0;

        case (state_q)
            ST_ALIGN: begin
                shreg_d = w_shift;
                cnt_d   = 6'd1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // In Philips mode the bit under the ws edge still belongs to
                // the slot that is ending.
                if (w_active && (!w_edge || phil_q)) begin
                    shreg_d = w_shift;
                    cnt_d   = w_cnt_inc;
                    if (w_cnt_inc == w_slot_len) begin
                        w_push = !ch_q || stereo_q;
                    end
                end
                if (w_edge && w_active && !(phil_q && (w_cnt_inc == w_slot_len))) begin
                    sync_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        // A ws edge starts a new slot (ALIGN passes straight through).
        if (w_edge && (state_q != ST_ALIGN)) begin
            ch_d     = ws;
            phil_d   = w_in_phil;
            rj_d     = w_in_rj;
            w32_d    = frame_size;
            stereo_d = stereo;
            if (w_in_phil) begin
                state_d = ST_ALIGN;
                cnt_d   = 6'd0;
            end else begin
                state_d = ST_SHIFT;
                shreg_d = {31'h0, sd};
                cnt_d   = 6'd1;
            end
        end
    end

    // Framer registers.
    always_ff @(posedge rclk) begin
        if (!rst) begin
            state_q    <= ST_SYNC;
            ws_q       <= 1'b0;
            cnt_q      <= 6'd0;
            shreg_q    <= 32'h0;
            ch_q       <= 1'b0;
            phil_q     <= 1'b0;
            rj_q       <= 1'b0;
            w32_q      <= 1'b0;
            stereo_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ws_q       <= ws;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            ch_q       <= ch_d;
            phil_q     <= phil_d;
            rj_q       <= rj_d;
            w32_q      <= w32_d;
            stereo_q   <= stereo_d;
            sync_err_q <= sync_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: circular store of {channel, word}.
    // ------------------------------------------------------------------
    logic [32:0]        mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_CNT_W-1:0] count_q;
    logic               overrun_q;
    logic               w_pop;
    logic               w_wr;

    assign w_pop = (count_q != '0) && dout_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign w_wr  = w_push && ((count_q != c_FULL) || w_pop);

    // Buffer storage, pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge rclk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 33'h0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (w_wr) begin
                mem_q[wr_ptr_q] <= {ch_q, w_word};
                wr_ptr_q        <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   count_q <= count_q + c_CNT_W'(1);
                2'b01:   count_q <= count_q - c_CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (w_push && !w_wr) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign dout       = mem_q[rd_ptr_q][31:0];
    assign dout_ch    = mem_q[rd_ptr_q][32];
    assign dout_valid = (count_q != '0);
    assign overrun    = overrun_q;
    assign sync_err   = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_rx_deser
//  Purpose  : Self-checking bench for i2s_rx_deser. A transmitter model
//             builds ws/sd streams from lists of words and the expected
//             received words with the cycle of their last bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_deser;

    logic        rclk = 1'b0;
    logic        rst;
    logic        sd;
    logic        ws;
    logic [1:0]  standard;
    logic        stereo;
    logic        frame_size;
    logic [31:0] dout;
    logic        dout_ch;
    logic        dout_valid;
    logic        dout_ready;
    logic        overrun;
    logic        sync_err;

    i2s_rx_deser #(.DEPTH(2)) u_dut (
        .rclk       (rclk),
        .rst        (rst),
        .sd         (sd),
        .ws         (ws),
        .standard   (standard),
        .stereo     (stereo),
        .frame_size (frame_size),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .sync_err   (sync_err)
    );

    always #5 rclk = ~rclk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] d;
        bit          ch;
        int          lsb;
    } exp_t;

    bit   ws_s[$];
    bit   sd_s[$];
    bit   serr_s[$];
    exp_t exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_word(input int mode, input bit ch);
        case (mode)
            1:       return ch ? 32'h0000_0000 : 32'hFFFF_FFFF;
            2:       return ch ? 32'h1234_0000 : 32'hA5C3_0000;
            3:       return 32'hBEEF_0000;
            default: return $urandom;
        endcase
    endfunction

    // Build a stream of slots starting on the right channel. Slot trunc_at
    // is cut to 10 bits and must raise sync_err at the next slot start.
    task automatic build(input int std, input bit w32, input bit st, input int nslots,
                         input int trunc_at, input int mode);
        bit          lj[$];
        int          w;
        bit          phil;
        bit          rj;
        bit          ch;
        int          len;
        int          start;
        int          serr_idx;
        logic [31:0] word;
        bit          b;
        exp_t        e;
        ws_s.delete(); sd_s.delete(); serr_s.delete(); exp_q.delete();
        w        = w32 ? 32 : 16;
        phil     = (std == 0) || (std == 3);
        rj       = (std == 2);
        ch       = 1'b1;
        serr_idx = -1;
        for (int s = 0; s < nslots; s++) begin
            len   = (s == trunc_at) ? 10 : w;
            word  = pick_word(mode, ch);
            start = ws_s.size();
            for (int j = 0; j < len; j++) begin
                if (rj && w32) begin
                    if (j < 16) b = (mode == 3) ? 1'b0 : 1'($urandom_range(0, 1));
                    else        b = word[31 - (j - 16)];
                end else begin
                    b = word[31 - j];
                end
                ws_s.push_back(ch);
                lj.push_back(b);
                serr_s.push_back(1'b0);
            end
            if (len < w) begin
                serr_idx = start + len;
            end else if (!ch || st) begin
                e.d   = (w32 && !rj) ? word : {word[31:16], 16'h0000};
                e.ch  = ch;
                e.lsb = start + w - 1 + (phil ? 1 : 0);
                exp_q.push_back(e);
            end
            ch = ~ch;
        end
        // Tail keeps ws steady so a Philips LSB can still arrive.
        for (int j = 0; j < 3; j++) begin
            ws_s.push_back(~ch);
            lj.push_back(1'($urandom_range(0, 1)));
            serr_s.push_back(1'b0);
        end
        if (serr_idx >= 0) serr_s[serr_idx] = 1'b1;
        for (int i = 0; i < lj.size(); i++) begin
            if (phil) sd_s.push_back((i == 0) ? 1'($urandom_range(0, 1)) : lj[i-1]);
            else      sd_s.push_back(lj[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ws  = 1'b0;
        sd  = 1'b0;
        repeat (2) begin
            @(posedge rclk);
            #1;
        end
        rst = 1'b1;
    endtask

    // Play the stream; when chk is set every popped word is compared.
    task automatic run(input bit chk);
        exp_t e;
        for (int i = 0; i < ws_s.size(); i++) begin
            ws = ws_s[i];
            sd = sd_s[i];
            @(posedge rclk);
            #1;
            check_val("sync_err", {31'h0, sync_err}, {31'h0, serr_s[i]});
            if (chk && dout_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_word", dout, 32'hXXXX_XXXX ^ dout);
                end else begin
                    e = exp_q.pop_front();
                    check_val("data", dout, e.d);
                    check_val("ch", {31'h0, dout_ch}, {31'h0, e.ch});
                    check_val("latency", 32'(i), 32'(e.lsb));
                end
            end
        end
        if (chk) begin
            check_val("missing_words", 32'(exp_q.size()), 32'd0);
            check_val("overrun_clear", {31'h0, overrun}, 32'd0);
        end
    endtask

    task automatic test(input int std, input bit w32, input bit st, input int nslots,
                        input int trunc_at, input int mode);
        standard   = 2'(std);
        frame_size = w32;
        stereo     = st;
        dout_ready = 1'b1;
        do_reset();
        build(std, w32, st, nslots, trunc_at, mode);
        run(1'b1);
    endtask

    exp_t e0, e1;

    initial begin
        rst        = 1'b0;
        ws         = 1'b0;
        sd         = 1'b0;
        standard   = 2'b00;
        stereo     = 1'b1;
        frame_size = 1'b1;
        dout_ready = 1'b1;
        do_reset();
        check_val("rst_dout", dout, 32'h0);
        check_val("rst_ch", {31'h0, dout_ch}, 32'h0);
        check_val("rst_valid", {31'h0, dout_valid}, 32'h0);
        check_val("rst_overrun", {31'h0, overrun}, 32'h0);
        check_val("rst_sync_err", {31'h0, sync_err}, 32'h0);

        test(0, 1'b1, 1'b1, 6, -1, 1);   // Philips 32-bit all-ones / zeros
        test(1, 1'b0, 1'b1, 5, -1, 2);   // left-justified 16-bit
        test(2, 1'b1, 1'b1, 4, -1, 3);   // right-justified 32-bit BEEF
        test(1, 1'b1, 1'b0, 8, -1, 0);   // mono: 4 left words only
        test(1, 1'b1, 1'b1, 4, 1, 0);    // premature edge, left-justified
        test(0, 1'b1, 1'b1, 4, 1, 0);    // premature edge, Philips
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                test(s, 1'(w), 1'b1, 5, -1, 0);
            end
        end

        // Backpressure: three words into a two-entry buffer.
        standard   = 2'b01;
        frame_size = 1'b1;
        stereo     = 1'b1;
        dout_ready = 1'b0;
        do_reset();
        build(1, 1'b1, 1'b1, 3, -1, 0);
        e0 = exp_q[0];
        e1 = exp_q[1];
        run(1'b0);
        check_val("bp_overrun", {31'h0, overrun}, 32'h1);
        check_val("bp_valid", {31'h0, dout_valid}, 32'h1);
        check_val("bp_head", dout, e0.d);
        check_val("bp_head_ch", {31'h0, dout_ch}, {31'h0, e0.ch});
        dout_ready = 1'b1;
        @(posedge rclk);
        #1;
        check_val("bp_second", dout, e1.d);
        check_val("bp_second_ch", {31'h0, dout_ch}, {31'h0, e1.ch});
        check_val("bp_second_valid", {31'h0, dout_valid}, 32'h1);
        @(posedge rclk);
        #1;
        check_val("bp_empty", {31'h0, dout_valid}, 32'h0);
        check_val("bp_overrun_sticky", {31'h0, overrun}, 32'h1);

        // Reset in the middle of a slot.
        ws = ~ws;
        for (int i = 0; i < 5; i++) begin
            sd = 1'($urandom_range(0, 1));
            @(posedge rclk);
            #1;
        end
        rst = 1'b0;
        @(posedge rclk);
        #1;
        check_val("mid_rst_dout", dout, 32'h0);
        check_val("mid_rst_ch", {31'h0, dout_ch}, 32'h0);
        check_val("mid_rst_valid", {31'h0, dout_valid}, 32'h0);
        check_val("mid_rst_overrun", {31'h0, overrun}, 32'h0);
        check_val("mid_rst_sync_err", {31'h0, sync_err}, 32'h0);
        test(0, 1'b1, 1'b1, 4, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
